// File: rtl/sar_search_pkg.sv
// sar_search_pkg: shared types and constants for the 16-bit SAR search.
// Holds the FSM state enum, the data width and the sample-count ceiling.
package sar_search_pkg;

   localparam int WIDTH    = 16;
   localparam int MAX_ITER = 17;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_TEST   = 2'd1,
      S_VERIFY = 2'd2,
      S_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/mag_comp16.sv
// mag_comp16: combinational 16-bit magnitude comparator (external responder).
// Ports: a, b data in; eq = a==b, gt = a>b, lt = a<b.
module mag_comp16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        eq,
   output logic        gt,
   output logic        lt
);

   assign eq = (a == b);
   assign gt = (a > b);
   assign lt = (a < b);

endmodule

// File: rtl/sar_search16.sv
// sar_search16: successive-approximation search against an external comparator.
// Ports: clk, reset (sync, high), start; probe to comparator A; cmp_eq/gt/lt
// flags back; busy, done pulse, result, found, error, iter_cnt status.
module sar_search16
   import sar_search_pkg::*;
#(
   parameter int SETTLE = 0,
   parameter int WIDTH  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic [WIDTH-1:0] probe,
   input  logic             cmp_eq,
   input  logic             cmp_gt,
   input  logic             cmp_lt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             found,
   output logic             error,
   output logic [4:0]       iter_cnt
);

   localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_trial;
   logic [WIDTH-1:0] r_probe;
   logic [WIDTH-1:0] r_result;
   logic [3:0]       r_k;
   logic [1:0]       r_settle;
   logic [4:0]       r_iter;
   logic             r_found;
   logic             r_error;

   logic [WIDTH-1:0] w_bit;
   logic [WIDTH-1:0] w_next;
   logic             w_sample;
   logic             w_onehot;

   assign w_bit    = WIDTH'(1) << r_k;
   // lt means the probe is still below the target, so keep this bit
   assign w_next   = cmp_lt ? (r_trial | w_bit) : r_trial;
   // sample on the last cycle of the 1+SETTLE hold window
   assign w_sample = (r_settle == 2'(SETTLE));
   assign w_onehot = $onehot({cmp_eq, cmp_gt, cmp_lt});

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_trial  <= '0;
         r_probe  <= '0;
         r_result <= '0;
         r_k      <= '0;
         r_settle <= '0;
         r_iter   <= '0;
         r_found  <= 1'b0;
         r_error  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state  <= S_TEST;
                  r_trial  <= '0;
                  r_probe  <= MSB;
                  r_k      <= 4'd15;
                  r_settle <= '0;
                  r_iter   <= '0;
                  r_found  <= 1'b0;
                  r_error  <= 1'b0;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_TEST: begin
               if (!w_sample) begin
                  r_settle <= r_settle + 2'd1;
               end else begin
                  r_settle <= '0;
                  r_iter   <= r_iter + 5'd1;
                  if (!w_onehot) begin
                     r_error  <= 1'b1;
                     r_found  <= 1'b0;
                     r_result <= r_probe;
                     r_state  <= S_DONE;
                  end else if (cmp_eq) begin
                     r_found  <= 1'b1;
                     r_result <= r_probe;
                     r_state  <= S_DONE;
                  end else if (r_k == 4'd0) begin
                     r_trial <= w_next;
                     r_probe <= w_next;
                     r_state <= S_VERIFY;
                  end else begin
                     r_trial <= w_next;
                     r_k     <= r_k - 4'd1;
                     r_probe <= w_next | (w_bit >> 1);
                  end
               end
            end
            S_VERIFY: begin
               if (!w_sample) begin
                  r_settle <= r_settle + 2'd1;
               end else begin
                  r_settle <= '0;
                  r_iter   <= r_iter + 5'd1;
                  r_state  <= S_DONE;
                  if (!w_onehot) begin
                     r_error  <= 1'b1;
                     r_found  <= 1'b0;
                     r_result <= r_probe;
                  end else begin
                     r_found  <= cmp_eq;
                     r_result <= r_trial;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign probe    = r_probe;
   assign result   = r_result;
   assign found    = r_found;
   assign error    = r_error;
   assign iter_cnt = r_iter;
   assign busy     = (r_state == S_TEST) || (r_state == S_VERIFY);
   assign done     = (r_state == S_DONE);

endmodule
